// File: rtl/operand2_fetch_if.sv
// Bundle of handshake, register-file and shifter-operand signals for operand2_fetch.
// The slave modport is the fetch block; master is everything around it.
// Optional macro OP2_PC_ADJ_EN adds pc_in.
interface operand2_fetch_if #(
    parameter int unsigned RF_AW = 4,
    parameter int unsigned DW    = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic             carry_in;
`ifdef OP2_PC_ADJ_EN
    logic [DW-1:0]    pc_in;
`endif
    logic             rf_ren;
    logic [RF_AW-1:0] rf_raddr;
    logic [DW-1:0]    rf_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    Shift_Data;
    logic [7:0]       Shift_Num;
    logic [2:0]       SHIFT_OP;
    logic             Carry_flag;

    modport slave (
        input  flush, in_valid, inst, carry_in, rf_rdata, out_ready,
`ifdef OP2_PC_ADJ_EN
        input  pc_in,
`endif
        output in_ready, rf_ren, rf_raddr, out_valid, Shift_Data, Shift_Num, SHIFT_OP,
        output Carry_flag
    );

    modport master (
        output flush, in_valid, inst, carry_in, rf_rdata, out_ready,
`ifdef OP2_PC_ADJ_EN
        output pc_in,
`endif
        input  in_ready, rf_ren, rf_raddr, out_valid, Shift_Data, Shift_Num, SHIFT_OP,
        input  Carry_flag
    );
endinterface

// File: rtl/operand2_fetch.sv
// Operand-2 front end: decodes the shifter-operand field of an ARM data-processing
// instruction, reads Rm/Rs over one synchronous register-file port and presents a
// registered {Shift_Data, Shift_Num, SHIFT_OP, Carry_flag} bundle to the barrel shifter.
// Optional macro OP2_PC_ADJ_EN: substitutes pipelined PC values for r15 reads.
module operand2_fetch #(
    parameter int unsigned RF_AW = 4,
    parameter int unsigned DW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    operand2_fetch_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRdRm,
        StRdRs,
        StCap,
        StValid
    } state_e;

    state_e           state_q;
    logic [11:0]      inst_q;      // only the shifter-operand field is needed after accept
    logic             carry_q;
    logic             out_valid_q;
    logic             rf_ren_q;
    logic [RF_AW-1:0] rf_raddr_q;
    logic [DW-1:0]    shift_data_q;
    logic [7:0]       shift_num_q;
    logic [2:0]       shift_op_q;

    logic [DW-1:0]    rm_data;
    logic [7:0]       rs_byte;

    // Condition field and opcode bits are irrelevant to operand 2.
    logic unused_inst;
    assign unused_inst = ^{bus.inst[31:26], bus.inst[24:12]};

`ifdef OP2_PC_ADJ_EN
    logic [DW-1:0] pc_q;
    logic [DW-1:0] pc_plus8;
    logic [DW-1:0] pc_plus12;

    assign pc_plus8  = pc_q + DW'(8);
    assign pc_plus12 = pc_q + DW'(12);

    // r15 reads see the pipelined PC; the register-file data for r15 is discarded.
    always_comb begin
        rm_data = bus.rf_rdata;
        rs_byte = bus.rf_rdata[7:0];
        if (inst_q[3:0] == 4'd15) begin
            rm_data = inst_q[4] ? pc_plus12 : pc_plus8;
        end
        if (inst_q[11:8] == 4'd15) begin
            rs_byte = pc_plus12[7:0];
        end
    end
`else
    // Register-file data is used as-is; r15 is an ordinary register here.
    always_comb begin
        rm_data = bus.rf_rdata;
        rs_byte = bus.rf_rdata[7:0];
    end
`endif

    // Sequencer with registered outputs; rst beats flush, flush beats accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            inst_q       <= '0;
            carry_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            rf_ren_q     <= 1'b0;
            rf_raddr_q   <= '0;
            shift_data_q <= '0;
            shift_num_q  <= '0;
            shift_op_q   <= '0;
`ifdef OP2_PC_ADJ_EN
            pc_q         <= '0;
`endif
        end else if (bus.flush) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            rf_ren_q    <= 1'b0;
            rf_raddr_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        inst_q  <= bus.inst[11:0];
                        carry_q <= bus.carry_in;
`ifdef OP2_PC_ADJ_EN
                        pc_q    <= bus.pc_in;
`endif
                        if (bus.inst[25]) begin
                            // Rotated 8-bit immediate: rotate amount is twice the 4-bit field.
                            shift_data_q <= {{(DW-8){1'b0}}, bus.inst[7:0]};
                            shift_num_q  <= {3'b000, bus.inst[11:8], 1'b0};
                            shift_op_q   <= 3'b111;
                            out_valid_q  <= 1'b1;
                            state_q      <= StValid;
                        end else begin
                            rf_ren_q   <= 1'b1;
                            rf_raddr_q <= RF_AW'(bus.inst[3:0]);
                            state_q    <= StRdRm;
                        end
                    end
                end
                StRdRm: begin
                    if (inst_q[4]) begin
                        rf_raddr_q <= RF_AW'(inst_q[11:8]);
                        state_q    <= StRdRs;
                    end else begin
                        rf_ren_q   <= 1'b0;
                        rf_raddr_q <= '0;
                        state_q    <= StCap;
                    end
                end
                StRdRs: begin
                    // Rm arrives while Rs is being read.
                    shift_data_q <= rm_data;
                    rf_ren_q     <= 1'b0;
                    rf_raddr_q   <= '0;
                    state_q      <= StCap;
                end
                StCap: begin
                    if (inst_q[4]) begin
                        shift_num_q <= rs_byte;
                        shift_op_q  <= {inst_q[6:5], 1'b1};
                    end else begin
                        // Amount 0 is passed through; the shifter decodes LSR/ASR #32 and RRX.
                        shift_data_q <= rm_data;
                        shift_num_q  <= {3'b000, inst_q[11:7]};
                        shift_op_q   <= {inst_q[6:5], 1'b0};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= StValid;
                end
                StValid: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.rf_ren     = rf_ren_q;
    assign bus.rf_raddr   = rf_raddr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.Shift_Data = shift_data_q;
    assign bus.Shift_Num  = shift_num_q;
    assign bus.SHIFT_OP   = shift_op_q;
    assign bus.Carry_flag = carry_q;

endmodule

// File: tb/tb_operand2_fetch.sv
// Self-checking bench for operand2_fetch: directed cases, flush/reset aborts and
// randomized instructions checked against a field-level reference model.
module tb_operand2_fetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand2_fetch_if #(.RF_AW(4), .DW(32)) bus ();

    operand2_fetch #(.RF_AW(4), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] regs [16];
    logic [3:0]  rd_q [$];
    logic [31:0] pc;
    int          n_vec = 0;
    int          n_err = 0;

    // Register file: synchronous read, junk on the data bus when not reading.
    always @(posedge clk) begin
        if (bus.rf_ren) begin
            rd_q.push_back(bus.rf_raddr);
            bus.rf_rdata <= regs[bus.rf_raddr];
        end else begin
            bus.rf_rdata <= $urandom;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {Shift_Data, Shift_Num, SHIFT_OP} from the operand-2 encoding rules.
    function automatic logic [42:0] model(input logic [31:0] inst);
        logic [31:0] rmv;
        logic [31:0] rsv;
        logic [31:0] data;
        logic [7:0]  num;
        logic [2:0]  op;
        rmv = regs[inst[3:0]];
        rsv = regs[inst[11:8]];
`ifdef OP2_PC_ADJ_EN
        if (inst[3:0] == 4'd15) rmv = inst[4] ? pc + 32'd12 : pc + 32'd8;
        if (inst[11:8] == 4'd15) rsv = pc + 32'd12;
`endif
        if (inst[25]) begin
            data = 32'(inst[7:0]);
            num  = 8'(inst[11:8]) * 8'd2;
            op   = 3'b111;
        end else if (inst[4]) begin
            data = rmv;
            num  = rsv[7:0];
            op   = {inst[6:5], 1'b1};
        end else begin
            data = rmv;
            num  = 8'(inst[11:7]);
            op   = {inst[6:5], 1'b0};
        end
        return {data, num, op};
    endfunction

    task automatic run_op(input logic [31:0] inst, input logic c, input int hold,
                          input string tag);
        logic [42:0] exp;
        int          lat;
        int          exp_lat;
        logic [15:0] rd_obs;
        logic [15:0] rd_exp;
        exp     = model(inst);
        exp_lat = inst[25] ? 1 : (inst[4] ? 4 : 3);
        if (inst[25])     rd_exp = 16'h0000;
        else if (inst[4]) rd_exp = {8'd2, inst[3:0], inst[11:8]};
        else              rd_exp = {8'd1, inst[3:0], 4'h0};
        @(negedge clk);
        rd_q.delete();
        bus.inst      = inst;
        bus.carry_in  = c;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
`ifdef OP2_PC_ADJ_EN
        bus.pc_in     = pc;
`endif
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept so unlatched use shows up.
        bus.in_valid = 1'b0;
        bus.inst     = $urandom;
        bus.carry_in = ~c;
`ifdef OP2_PC_ADJ_EN
        bus.pc_in    = $urandom;
`endif
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".bundle"}, 64'({bus.Shift_Data, bus.Shift_Num, bus.SHIFT_OP}), 64'(exp));
        check({tag, ".carry"}, 64'(bus.Carry_flag), 64'(c));
        rd_obs = {8'(rd_q.size()), (rd_q.size() > 0) ? rd_q[0] : 4'h0,
                  (rd_q.size() > 1) ? rd_q[1] : 4'h0};
        check({tag, ".reads"}, 64'(rd_obs), 64'(rd_exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold"}, 64'({bus.out_valid, bus.in_ready, bus.Shift_Data,
                                       bus.Shift_Num, bus.SHIFT_OP, bus.Carry_flag}),
                  64'({1'b1, 1'b0, exp, c}));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".release"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
    endtask

    initial begin
        int cnt;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.inst      = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
        pc            = '0;
`ifdef OP2_PC_ADJ_EN
        bus.pc_in     = '0;
`endif
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        repeat (3) @(negedge clk);
        check("reset.outputs", 64'({bus.out_valid, bus.rf_ren, bus.rf_raddr, bus.Shift_Data,
                                    bus.Shift_Num, bus.SHIFT_OP, bus.Carry_flag}), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        run_op(32'hE3A004FF, 1'b1, 0, "rot_imm");
        regs[2] = 32'h12345678;
        run_op(32'hE1A00182, 1'b0, 0, "lsl_imm3");
        regs[2] = 32'h80000001;
        regs[3] = 32'hFFFFFF20;
        run_op(32'hE1A00312, 1'b1, 1, "lsl_reg");
        regs[2] = 32'hF0000000;
        run_op(32'hE1A00022, 1'b0, 5, "lsr0_hold");
`ifdef OP2_PC_ADJ_EN
        pc = 32'h00001000;
        run_op(32'hE1A0001F, 1'b0, 0, "pc_rm");
        run_op(32'hE1A00F12, 1'b1, 0, "pc_rs");
`endif

        // Flush while reading Rs: operation vanishes.
        @(negedge clk);
        bus.inst     = 32'hE1A00312;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_rdrs.rf_ren_before", 64'(bus.rf_ren), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_rdrs.state", 64'({bus.in_ready, bus.rf_ren, bus.out_valid}), 64'(3'b100));
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("flush_rdrs.no_valid", 64'(cnt), 64'd0);

        // Flush in the accept cycle: nothing is taken.
        @(negedge clk);
        bus.inst     = 32'hE3A004FF;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_accept", 64'({bus.in_ready, bus.out_valid, bus.rf_ren}), 64'(3'b100));

        // Flush while holding a valid bundle discards it.
        bus.inst     = 32'hE3A004FF;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("flush_valid.before", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_valid.after", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));

        // Reset in CAP clears every output.
        regs[2] = 32'h80000001;
        @(negedge clk);
        bus.inst     = 32'hE1A00312;
        bus.carry_in = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_cap.outputs", 64'({bus.out_valid, bus.rf_ren, bus.rf_raddr, bus.Shift_Data,
                                     bus.Shift_Num, bus.SHIFT_OP, bus.Carry_flag}), 64'd0);
        check("rst_cap.in_ready", 64'(bus.in_ready), 64'd1);

        // Randomized instructions against the model.
        for (int k = 0; k < 60; k++) begin
            regs[$urandom_range(0, 15)] = $urandom;
            pc = $urandom;
            run_op($urandom, 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
